// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: shift-mode encodings.
package shifter_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROR = 2'b11
  } shift_mode_e;

endpackage

// File: rtl/mutex.sv
// Single-bit 2:1 selector: out follows b when selector is 1, otherwise a.
module mutex (
  input  logic a,
  input  logic b,
  input  logic selector,
  output logic out
);

  assign out = selector ? b : a;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// log2(WIDTH)-stage barrel shifter (LSL/LSR/ASR/ROR); stage k conditionally shifts by 2^k.
// The whole pipe advances or stalls together under a single valid/ready enable.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  // Fixed-distance shift of one stage; ASR keeps the sign since every stage re-extends the MSB.
  function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] v,
                                                   input shift_mode_e      m,
                                                   input int               amt);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    case (m)
      MODE_LSL: return v << amt;
      MODE_LSR: return v >> amt;
      MODE_ASR: return sv >>> amt;
      MODE_ROR: return (v >> amt) | (v << (WIDTH - amt));
      default:  return v;
    endcase
  endfunction

  logic en;

  // Stage registers; the final stage's data lives in out_data_p.
  logic [WIDTH-1:0] data_p  [SHW-1];
  shift_mode_e      mode_p  [SHW-1];
  logic [SHW-1:0]   shamt_p [SHW-1];
  logic [SHW-1:0]   vld_p;
  logic [WIDTH-1:0] out_data_p;

  // Per-stage combinational inputs and results.
  logic [WIDTH-1:0] src      [SHW];
  logic [WIDTH-1:0] shifted  [SHW];
  logic [WIDTH-1:0] nxt      [SHW];
  shift_mode_e      mode_src [SHW];
  logic             sel      [SHW];

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_p[SHW-1];
  assign out_data  = out_data_p;
  assign out_zero  = ~|out_data_p;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign src[k]      = in_data;
      assign mode_src[k] = shift_mode_e'(in_mode);
      assign sel[k]      = in_shamt[0];
    end else begin : g_next
      assign src[k]      = data_p[k-1];
      assign mode_src[k] = mode_p[k-1];
      assign sel[k]      = shamt_p[k-1][0];
    end

    assign shifted[k] = stage_shift(src[k], mode_src[k], 1 << k);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      mutex u_mux (
        .a        (src[k][i]),
        .b        (shifted[k][i]),
        .selector (sel[k]),
        .out      (nxt[k][i])
      );
    end
  end

  // ---- stage boundary: valid bits (control, async reset) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else if (en) begin
      vld_p <= {vld_p[SHW-2:0], in_valid};
    end
  end

  // ---- stage boundary: inner data/mode/shamt registers ----
  // The shamt travels pre-shifted so each stage only ever looks at bit 0.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int k = 0; k < SHW-1; k++) begin
        data_p[k] <= nxt[k];
        mode_p[k] <= mode_src[k];
      end
      shamt_p[0] <= in_shamt >> 1;
      for (int k = 1; k < SHW-1; k++) begin
        shamt_p[k] <= shamt_p[k-1] >> 1;
      end
    end
  end

  // ---- stage boundary: output register, cleared so out_data reads 0 in reset ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_p <= '0;
    end else if (en) begin
      out_data_p <= nxt[SHW-1];
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed + random bench for pipelined_barrel_shifter (WIDTH = 8) with a queue scoreboard.
module tb_pipelined_barrel_shifter;

  localparam int WIDTH = 8;
  localparam int SHW   = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  int nchk = 0;
  int nerr = 0;
  int ncons = 0;
  int nacc = 0;
  logic [7:0] exp_q[$];

  pipelined_barrel_shifter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  // Reference: shift the operand inside a double-width word and keep the low byte.
  function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m);
    logic [15:0] w;
    case (m)
      2'b00:   w = {8'h00, d} << s;
      2'b01:   w = {8'h00, d} >> s;
      2'b10:   w = {{8{d[7]}}, d} >> s;
      default: w = {d, d} >> s;
    endcase
    return w[7:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample both handshakes mid-cycle, then step past the rising edge.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", out_data, e);
        check("sb_zero", out_zero, e == 8'h00);
      end
      ncons++;
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(in_data, in_shamt, in_mode));
      nacc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int bound;
    bound = 0;
    while (exp_q.size() > 0 && bound < 60) begin
      tick();
      bound++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic rand_op();
    in_data  = 8'($urandom);
    in_shamt = 3'($urandom_range(0, 7));
    in_mode  = 2'($urandom_range(0, 3));
  endtask

  task automatic run_dir(input string tag, input logic [7:0] d, input logic [2:0] s,
                         input logic [1:0] m, input logic [7:0] exp);
    int lat;
    in_data   = d;
    in_shamt  = s;
    in_mode   = m;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 3);
    check(tag, out_data, exp);
    check({tag, "_zero"}, out_zero, exp == 8'h00);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    logic [7:0] held;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    in_shamt  = '0;
    in_mode   = '0;
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_zero", out_zero, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed single operations, first one right after reset release.
    run_dir("lsl_96_3", 8'h96, 3'd3, 2'b00, 8'hB0);
    run_dir("asr_96_2", 8'h96, 3'd2, 2'b10, 8'hE5);
    run_dir("ror_96_3", 8'h96, 3'd3, 2'b11, 8'hD2);
    run_dir("lsr_96_0", 8'h96, 3'd0, 2'b01, 8'h96);
    run_dir("lsr_01_1", 8'h01, 3'd1, 2'b01, 8'h00);
    run_dir("lsl_a5_7", 8'hA5, 3'd7, 2'b00, 8'h80);
    run_dir("asr_96_7", 8'h96, 3'd7, 2'b10, 8'hFF);
    run_dir("ror_69_7", 8'h69, 3'd7, 2'b11, 8'hD2);

    // Back-to-back: 8 ops accepted on 8 edges must all be consumed 3 edges after the last.
    n0 = ncons;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_op();
      in_valid = 1'b1;
      check("b2b_in_ready", in_ready, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    check("b2b_count", ncons - n0, 8);
    check("b2b_empty", exp_q.size(), 0);

    // Backpressure: fill the pipe, stall 5 cycles with a pending op, then release.
    n0 = ncons;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_op();
      in_valid = 1'b1;
      tick();
    end
    rand_op();
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_hold", out_data, held);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    drain();
    check("bp_count", ncons - n0, 4);

    // Random traffic with random bubbles and backpressure.
    for (int i = 0; i < 80; i++) begin
      rand_op();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    check("rand_acc_eq_cons", nacc, ncons);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      rand_op();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_data", out_data, 8'h00);
    check("midrst_out_zero", out_zero, 1'b1);
    exp_q.delete();
    n0 = ncons;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) tick();
    check("midrst_no_stale", ncons - n0, 0);
    run_dir("post_rst_lsl", 8'h96, 3'd3, 2'b00, 8'hB0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data width; legal values are powers of two from 4 to 64.
REQ-002 The block SHALL have derived localparam SHW, equal to log2(WIDTH), giving the shift-amount width and the pipeline depth.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an input operation is present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an operation this cycle.
REQ-007 The block SHALL have port in_data, input, WIDTH bits: operand.
REQ-008 The block SHALL have port in_shamt, input, SHW bits: shift amount, 0..WIDTH-1.
REQ-009 The block SHALL have port in_mode, input, 2 bits: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data holds a result.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port out_data, output, WIDTH bits: shifted result.
REQ-013 The block SHALL have port out_zero, output, 1 bit: out_data equals 0, valid when out_valid is 1.

Function
REQ-014 An operation SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-015 A result SHALL be consumed on a rising edge where out_valid and out_ready are both 1.
REQ-016 The datapath SHALL be SHW registered stages; stage k shifts by 2^k when shamt bit k is 1, otherwise it passes the data through.
REQ-017 Each stage register SHALL carry data, mode, the remaining shamt bits and a valid bit.
REQ-018 The pipeline enable SHALL be (!out_valid || out_ready); when it is 1, all stages advance together, and when it is 0, all stages hold.
REQ-019 in_ready SHALL equal the pipeline enable, combinationally; there is no combinational path from in_valid to in_ready.
REQ-020 Latency SHALL be exactly SHW cycles from acceptance to out_valid when there is no backpressure.
REQ-021 Throughput SHALL be one operation per cycle when out_ready is held at 1.
REQ-022 LSL SHALL zero-fill from the LSB side.
REQ-023 LSR SHALL zero-fill from the MSB side.
REQ-024 ASR SHALL replicate in_data[WIDTH-1] into the vacated MSB positions.
REQ-025 ROR SHALL wrap bits shifted out at bit 0 back in at bit WIDTH-1.
REQ-026 A shamt of 0 SHALL return in_data unchanged in every mode.
REQ-027 An in_shamt of WIDTH-1 SHALL be legal; LSL gives in_data[0] at the MSB with all other bits 0.
REQ-028 Bubbles (in_valid = 0 on an enabled cycle) SHALL propagate as valid = 0 and SHALL NOT alter any other stage.
REQ-029 When out_valid = 1 and out_ready = 0, out_data and out_zero SHALL remain stable until consumed.
REQ-030 On a simultaneous accept and consume in the same cycle, both SHALL take effect with no loss or duplication.

Reset
REQ-031 Assertion of rst_n = 0 SHALL immediately clear all stage valid bits and out_valid, independent of clk.
REQ-032 During reset, out_data SHALL be 0 and out_zero SHALL be 1.
REQ-033 During reset, in_ready SHALL be 1.
REQ-034 Reset mid-operation SHALL discard all in-flight operations; none SHALL emerge after reset deasserts.
REQ-035 The first acceptance SHALL be possible on the first rising edge after rst_n returns to 1.

Structure
REQ-036 Mode encodings (MODE_LSL, MODE_LSR, MODE_ASR, MODE_ROR) SHALL live in shared package shifter_pkg.
REQ-037 Per-bit 2:1 selection in each stage SHALL reuse the existing 2:1 sub-module mutex (ports a, b, selector, out), instantiated in generate loops.
REQ-038 Stage registers SHALL be in the top module; no other sub-modules SHALL be used.

Verification (WIDTH = 8, latency 3)
REQ-039 LSL: 8'h96, shamt 3 -> 8'hB0 exactly 3 cycles later, out_zero = 0.
REQ-040 ASR: 8'h96, shamt 2 -> 8'hE5; ROR: 8'h96, shamt 3 -> 8'hD2; LSR: 8'h96, shamt 0 -> 8'h96.
REQ-041 Back-to-back: 8 ops on consecutive cycles with out_ready = 1 -> 8 results on consecutive cycles, in order.
REQ-042 Backpressure: out_ready = 0 for 5 cycles with a full pipe -> in_ready = 0, out_data stable, no result lost, order preserved after release.
REQ-043 Zero flag: LSR of 8'h01 by 1 -> out_data = 8'h00, out_zero = 1.
REQ-044 Reset with 3 ops in flight -> out_valid = 0 immediately, and no stale result appears after release.
